// File: rtl/xbus_vec_rd_arb.sv
// ============================================================================
//  Module   : xbus_vec_rd_arb
//  Purpose  : Round-robin burst arbiter draining P vector FIFOs into a single
//             two-entry in-order output buffer with source tagging.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module xbus_vec_rd_arb #(
    parameter int P     = 4,
    parameter int S     = 4,
    parameter int BURST = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [P-1:0]           fifo_empty,
    output logic [P-1:0]           fifo_rd_en,
    input  logic [P*S*8-1:0]       fifo_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [S*8-1:0]         m_data,
    output logic [$clog2(P)-1:0]   m_src
);

    localparam int c_PW = $clog2(P);
    localparam int c_DW = S * 8;
    localparam int c_SW = (c_PW < 3) ? 3 : c_PW;
    localparam int c_BW = $clog2(BURST + 1);

    localparam logic [0:0]      c_IDLE      = 1'b0;
    localparam logic [0:0]      c_GRANT     = 1'b1;
    localparam logic [c_PW-1:0] c_LAST_RST  = c_PW'(P - 1);
    localparam logic [c_BW-1:0] c_BEAT_LAST = c_BW'(BURST - 1);

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [c_PW-1:0] r_cur;
    logic [c_PW-1:0] r_last;
    logic [c_PW-1:0] r_rd_ch;
    logic [c_PW-1:0] w_pick;
    logic [c_PW-1:0] w_sel;
    logic [c_BW-1:0] r_beat;
    logic            r_inflight;
    logic [1:0]      r_occ;
    logic [c_DW-1:0] r_data [2];
    logic [c_SW-1:0] r_src  [2];
    logic            w_found;
    logic            w_rd;
    logic            w_pop;
    logic            w_space;
    logic            w_leave;
    logic [2:0]      w_fill;
    logic [1:0]      w_slot_calc;
    logic            w_slot;
    logic [c_DW-1:0] w_din;
    int              w_idx;

    assign m_valid = (r_occ != 2'd0);
    assign w_pop   = m_valid & m_ready;
    assign m_data  = r_data[0];
    assign m_src   = r_src[0][c_PW-1:0];

    // Occupancy the buffer will reach once the in-flight word lands and the pop retires
    assign w_fill      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_space     = (w_fill < 3'd2);
    assign w_slot_calc = r_occ - {1'b0, w_pop};
    assign w_slot      = w_slot_calc[0];

    assign w_rd    = (r_state == c_GRANT) && !fifo_empty[r_cur] && w_space;
    assign w_leave = (r_state == c_GRANT) &&
                     ((w_rd && (r_beat == c_BEAT_LAST)) || (fifo_empty[r_cur] && !w_rd));

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = 0; k < P; k++) begin
            w_idx = (int'(r_last) + 1 + k) % P;
            w_sel = c_PW'(w_idx);
            if (!w_found && !fifo_empty[w_sel]) begin
                w_found = 1'b1;
                w_pick  = w_sel;
            end
        end
    end

    always_comb begin
        w_din = '0;
        for (int i = 0; i < P; i++) begin
            if (r_rd_ch == c_PW'(i)) begin
                w_din = fifo_dout[i*c_DW +: c_DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found) w_state_nxt = c_GRANT;
            c_GRANT: if (w_leave) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en = '0;
        if (w_rd) begin
            fifo_rd_en[r_cur] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cur      <= '0;
            r_last     <= c_LAST_RST;
            r_beat     <= '0;
            r_inflight <= 1'b0;
            r_rd_ch    <= '0;
        end else begin
            r_inflight <= w_rd;
            if (w_rd) begin
                r_rd_ch <= r_cur;
                r_beat  <= r_beat + c_BW'(1);
            end
            if ((r_state == c_IDLE) && w_found) begin
                r_cur  <= w_pick;
                r_beat <= '0;
            end
            if (w_leave) begin
                r_last <= r_cur;
            end
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 forward and capture lands behind it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ     <= 2'd0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_src[0]  <= '0;
            r_src[1]  <= '0;
        end else begin
            r_occ <= w_fill[1:0];
            if (w_pop) begin
                r_data[0] <= r_data[1];
                r_src[0]  <= r_src[1];
            end
            if (r_inflight) begin
                r_data[w_slot] <= w_din;
                r_src[w_slot]  <= c_SW'(r_rd_ch);
            end
        end
    end

    generate
        if (c_SW > c_PW) begin : g_tag_pad
            logic w_unused_tag_hi;
            assign w_unused_tag_hi = ^r_src[0][c_SW-1:c_PW];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_xbus_vec_rd_arb.sv
// ============================================================================
//  Module   : tb_xbus_vec_rd_arb
//  Purpose  : Directed and random checks of xbus_vec_rd_arb against a FIFO
//             model and per-channel ordering scoreboard.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_xbus_vec_rd_arb;

    localparam int P     = 4;
    localparam int S     = 4;
    localparam int BURST = 2;
    localparam int DW    = S * 8;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rstn;
    logic [P-1:0]      fifo_empty;
    logic [P-1:0]      fifo_rd_en;
    logic [P*DW-1:0]   fifo_dout;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_src;

    logic [DW-1:0]     mem [P][DEPTH];
    logic [DW-1:0]     dout_r [P];
    int                wp [P]     = '{default: 0};
    int                rp [P]     = '{default: 0};
    int                exp_rp [P] = '{default: 0};
    int                rd_cnt [P] = '{default: 0};
    int                n_vec = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                valid_cyc = 0;
    int                first_rd = -1;
    int                last_rd = -1;
    int                src_log [$];

    xbus_vec_rd_arb #(.P(P), .S(S), .BURST(BURST)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_src      (m_src)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_empty = '0;
        fifo_dout  = '0;
        for (int i = 0; i < P; i++) begin
            fifo_empty[i]           = (rp[i] == wp[i]);
            fifo_dout[i*DW +: DW]   = dout_r[i];
        end
    end

    // FIFO model: one-cycle read latency
    always @(posedge clk) begin
        for (int i = 0; i < P; i++) begin
            if (fifo_rd_en[i] && (rp[i] != wp[i])) begin
                dout_r[i] <= mem[i][rp[i]];
                rp[i]     <= rp[i] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            exp_rp = rp;
        end else begin
            for (int i = 0; i < P; i++) begin
                if (fifo_rd_en[i]) begin
                    rd_cnt[i]++;
                    chk("rd_nonempty", 64'(fifo_empty[i]), 64'd0);
                end
            end
            if (|fifo_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (m_valid) valid_cyc++;
            if (m_valid && m_ready) begin
                if (exp_rp[int'(m_src)] < DEPTH)
                    chk("order", 64'(m_data), 64'(mem[int'(m_src)][exp_rp[int'(m_src)]]));
                exp_rp[int'(m_src)]++;
                src_log.push_back(int'(m_src));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][wp[ch]] = {8'(ch), 8'hA5, 16'(wp[ch])};
            wp[ch]++;
        end
    endtask

    task automatic clr();
        for (int i = 0; i < P; i++) rd_cnt[i] = 0;
        valid_cyc = 0;
        first_rd  = -1;
        last_rd   = -1;
        src_log.delete();
    endtask

    task automatic drain(input string tag);
        int quiet;
        int t;
        quiet   = 0;
        t       = 0;
        m_ready = 1'b1;
        while (quiet < 4 && t < 400) begin
            tick(1);
            t++;
            if ((fifo_empty == '1) && !m_valid) quiet++;
            else quiet = 0;
        end
        chk({tag, "_drained"}, 64'(quiet >= 4), 64'd1);
    endtask

    function automatic int log_at(input int k);
        return (k < src_log.size()) ? src_log[k] : -1;
    endfunction

    initial begin
        int t;
        int rd_start;
        logic [DW-1:0] held;
        int exp_ee [4];

        rstn    = 1'b0;
        m_ready = 1'b0;
        tick(3);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_rden",  64'(fifo_rd_en), 64'd0);
        chk("rst_data",  64'(m_data), 64'd0);
        chk("rst_src",   64'(m_src), 64'd0);
        rstn = 1'b1;
        tick(2);
        chk("idle_valid", 64'(m_valid), 64'd0);

        // Round robin, two beats per grant
        clr();
        m_ready = 1'b1;
        for (int ch = 0; ch < P; ch++) push(ch, 4);
        drain("rr");
        chk("rr_count", 64'(src_log.size()), 64'd16);
        for (int k = 0; k < 16; k++) chk("rr_src", 64'(log_at(k)), 64'((k / 2) % 4));
        chk("rr_span", 64'(last_rd - first_rd), 64'd22);

        // Backpressure mid-burst on channel 1
        clr();
        push(1, 6);
        t = 0;
        while (!m_valid && t < 20) begin tick(1); t++; end
        chk("bp_start", 64'(m_valid), 64'd1);
        m_ready  = 1'b0;
        rd_start = rd_cnt[1];
        tick(1);
        held = m_data;
        tick(9);
        chk("bp_reads_le2", 64'((rd_cnt[1] - rd_start) <= 2), 64'd1);
        chk("bp_hold_data", 64'(m_data), 64'(held));
        chk("bp_hold_valid", 64'(m_valid), 64'd1);
        chk("bp_hold_src", 64'(m_src), 64'd1);
        drain("bp");
        chk("bp_total", 64'(rd_cnt[1]), 64'd6);
        chk("bp_no_loss", 64'(exp_rp[1]), 64'(wp[1]));

        // Early empty: channel 2 runs dry before the burst limit
        clr();
        push(2, 1);
        push(3, 2);
        push(0, 1);
        drain("ee");
        exp_ee = '{2, 3, 3, 0};
        chk("ee_count", 64'(src_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk("ee_src", 64'(log_at(k)), 64'(exp_ee[k]));
        chk("ee_rd2", 64'(rd_cnt[2]), 64'd1);

        // Sparse: single word on channel 3
        clr();
        push(3, 1);
        drain("sp");
        chk("sp_rd3", 64'(rd_cnt[3]), 64'd1);
        chk("sp_rd_other", 64'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2]), 64'd0);
        chk("sp_valid_cyc", 64'(valid_cyc), 64'd1);
        chk("sp_src", 64'(log_at(0)), 64'd3);

        // Reset while a grant is stalled with two words buffered
        clr();
        m_ready = 1'b0;
        push(2, 2);
        push(3, 8);
        tick(12);
        chk("rs_pre_valid", 64'(m_valid), 64'd1);
        chk("rs_pre_src", 64'(m_src), 64'd2);
        push(1, 2);
        #2 rstn = 1'b0;
        #1;
        chk("rs_valid", 64'(m_valid), 64'd0);
        chk("rs_rden", 64'(fifo_rd_en), 64'd0);
        chk("rs_data", 64'(m_data), 64'd0);
        tick(2);
        rstn = 1'b1;
        t = 0;
        while (fifo_rd_en == '0 && t < 20) begin tick(1); t++; end
        chk("rs_first_grant", 64'(fifo_rd_en), 64'b0010);
        drain("rs");
        for (int ch = 0; ch < P; ch++) chk("rs_no_loss", 64'(exp_rp[ch]), 64'(wp[ch]));

        // Random load and backpressure
        clr();
        for (int c = 0; c < 300; c++) begin
            for (int ch = 0; ch < P; ch++) begin
                if ($urandom_range(0, 3) == 0) push(ch, 1);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        drain("rnd");
        for (int ch = 0; ch < P; ch++) chk("rnd_no_loss", 64'(exp_rp[ch]), 64'(wp[ch]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
